// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind uart_rx: captures byte strobes and presents them as a show-ahead valid/ready stream.
// Define UART_RX_FIFO_THRESH_EN to add the registered o_thresh fill-level flag (RX interrupt request).
module uart_rx_fifo #(
   parameter int DLEN   = 8,
   parameter int DEPTH  = 16,
   parameter int THRESH = 12
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       i_rvalid,
   input  logic [DLEN-1:0]            i_rdata,
   output logic                       o_tvalid,
   output logic [DLEN-1:0]            o_tdata,
   input  logic                       i_tready,
   output logic [$clog2(DEPTH):0]     o_level,
   output logic                       o_empty,
   output logic                       o_full,
   output logic                       o_overrun,
   input  logic                       i_overrun_clr
`ifdef UART_RX_FIFO_THRESH_EN
   ,
   output logic                       o_thresh
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DLEN-1:0] mem [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic            overrun_q, overrun_d;
   logic            empty, full, push, pop, drop;

   // Extra wrap bit distinguishes full from empty when the index bits match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

   assign pop  = !empty && i_tready;
   assign push = i_rvalid && (!full || pop);
   assign drop = i_rvalid && full && !pop;

   assign wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
   assign rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
   assign overrun_d = drop ? 1'b1 : (i_overrun_clr ? 1'b0 : overrun_q);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q[AW-1:0]] <= i_rdata;
   end

   assign o_level   = wr_ptr_q - rd_ptr_q;
   assign o_empty   = empty;
   assign o_full    = full;
   assign o_tvalid  = !empty;
   assign o_tdata   = mem[rd_ptr_q[AW-1:0]];
   assign o_overrun = overrun_q;

`ifdef UART_RX_FIFO_THRESH_EN
   logic [PW-1:0] level_d;
   logic          thresh_q;

   assign level_d = wr_ptr_d - rd_ptr_d;

   always_ff @(posedge clk) begin
      if (!rstn) thresh_q <= 1'b0;
      else       thresh_q <= (level_d >= PW'(THRESH));
   end

   assign o_thresh = thresh_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic vs a queue model.
module tb_uart_rx_fifo;

   localparam int DLEN   = 8;
   localparam int DEPTH  = 16;
   localparam int THRESH = 12;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            i_rvalid = 1'b0;
   logic [DLEN-1:0] i_rdata = '0;
   logic            i_tready = 1'b0;
   logic            i_overrun_clr = 1'b0;
   logic            o_tvalid, o_empty, o_full, o_overrun;
   logic [DLEN-1:0] o_tdata;
   logic [4:0]      o_level;
`ifdef UART_RX_FIFO_THRESH_EN
   logic            o_thresh;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: an ordered queue of stored bytes and a sticky drop flag.
   logic [DLEN-1:0] mq [$];
   bit              mov = 1'b0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DLEN(DLEN), .DEPTH(DEPTH), .THRESH(THRESH)) dut (
      .clk(clk), .rstn(rstn),
      .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .o_tvalid(o_tvalid), .o_tdata(o_tdata), .i_tready(i_tready),
      .o_level(o_level), .o_empty(o_empty), .o_full(o_full),
      .o_overrun(o_overrun), .i_overrun_clr(i_overrun_clr)
`ifdef UART_RX_FIFO_THRESH_EN
      , .o_thresh(o_thresh)
`endif
   );

   // Apply one cycle of inputs, advance the model, and return 1 time unit after the edge.
   task automatic drive(input bit rv, input logic [DLEN-1:0] d, input bit tr, input bit clr, input bit rs);
      bit can_pop, was_full;
      i_rvalid = rv; i_rdata = d; i_tready = tr; i_overrun_clr = clr; rstn = rs;
      if (!rs) begin
         mq.delete();
         mov = 1'b0;
      end else begin
         can_pop  = (mq.size() > 0) && tr;
         was_full = (mq.size() == DEPTH);
         if (can_pop) void'(mq.pop_front());
         if (rv && (!was_full || can_pop)) mq.push_back(d);
         if (rv && was_full && !can_pop) mov = 1'b1;
         else if (clr)                   mov = 1'b0;
      end
      @(posedge clk); #1;
      i_rvalid = 1'b0; i_tready = 1'b0; i_overrun_clr = 1'b0; rstn = 1'b1;
   endtask

   task automatic test_reset();
      drive(0, '0, 0, 0, 0);
      n_cmp++; if (o_level !== 5'd0)  begin n_err++; $display("FAIL reset_level: got %0d want 0", o_level); end
      n_cmp++; if (o_empty !== 1'b1)  begin n_err++; $display("FAIL reset_empty: got %b want 1", o_empty); end
      n_cmp++; if (o_full !== 1'b0)   begin n_err++; $display("FAIL reset_full: got %b want 0", o_full); end
      n_cmp++; if (o_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", o_tvalid); end
      n_cmp++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", o_overrun); end
`ifdef UART_RX_FIFO_THRESH_EN
      n_cmp++; if (o_thresh !== 1'b0) begin n_err++; $display("FAIL reset_thresh: got %b want 0", o_thresh); end
`endif
   endtask

   task automatic test_single();
      drive(1, 8'hA5, 0, 0, 1);
      n_cmp++; if (o_tvalid !== 1'b1) begin n_err++; $display("FAIL single_tvalid: got %b want 1", o_tvalid); end
      n_cmp++; if (o_tdata !== 8'hA5) begin n_err++; $display("FAIL single_tdata: got %h want a5", o_tdata); end
      n_cmp++; if (o_level !== 5'd1)  begin n_err++; $display("FAIL single_level: got %0d want 1", o_level); end
      n_cmp++; if (o_empty !== 1'b0)  begin n_err++; $display("FAIL single_empty: got %b want 0", o_empty); end
      drive(0, '0, 1, 0, 1);
      n_cmp++; if (o_empty !== 1'b1)  begin n_err++; $display("FAIL single_drain_empty: got %b want 1", o_empty); end
   endtask

   task automatic test_fill_overrun();
      for (int i = 0; i < DEPTH; i++) drive(1, 8'(i), 0, 0, 1);
      n_cmp++; if (o_full !== 1'b1)   begin n_err++; $display("FAIL fill_full: got %b want 1", o_full); end
      n_cmp++; if (o_level !== 5'd16) begin n_err++; $display("FAIL fill_level: got %0d want 16", o_level); end
      n_cmp++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL fill_no_overrun: got %b want 0", o_overrun); end
      drive(1, 8'hFF, 0, 0, 1);
      n_cmp++; if (o_overrun !== 1'b1) begin n_err++; $display("FAIL drop_overrun: got %b want 1", o_overrun); end
      n_cmp++; if (o_level !== 5'd16) begin n_err++; $display("FAIL drop_level: got %0d want 16", o_level); end
      for (int i = 0; i < DEPTH; i++) begin
         n_cmp++;
         if (o_tvalid !== 1'b1 || o_tdata !== 8'(i)) begin
            n_err++; $display("FAIL drain_order[%0d]: got v=%b d=%h want v=1 d=%h", i, o_tvalid, o_tdata, 8'(i));
         end
         drive(0, '0, 1, 0, 1);
      end
      n_cmp++; if (o_empty !== 1'b1)  begin n_err++; $display("FAIL drain_empty: got %b want 1", o_empty); end
   endtask

   task automatic test_full_pushpop();
      drive(0, '0, 0, 1, 1);
      n_cmp++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL clr_alone: got %b want 0", o_overrun); end
      for (int i = 0; i < DEPTH; i++) drive(1, 8'(8'h20 + i), 0, 0, 1);
      drive(1, 8'h55, 1, 0, 1);
      n_cmp++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL pp_overrun: got %b want 0", o_overrun); end
      n_cmp++; if (o_level !== 5'd16) begin n_err++; $display("FAIL pp_level: got %0d want 16", o_level); end
      n_cmp++; if (o_tdata !== 8'h21) begin n_err++; $display("FAIL pp_head: got %h want 21", o_tdata); end
      for (int i = 0; i < DEPTH - 1; i++) drive(0, '0, 1, 0, 1);
      n_cmp++; if (o_tdata !== 8'h55 || o_level !== 5'd1) begin
         n_err++; $display("FAIL pp_last: got d=%h lvl=%0d want d=55 lvl=1", o_tdata, o_level);
      end
      drive(0, '0, 1, 0, 1);
      // Pop and push together on an empty FIFO: only the push takes effect.
      drive(1, 8'h77, 1, 0, 1);
      n_cmp++; if (o_level !== 5'd1 || o_tdata !== 8'h77) begin
         n_err++; $display("FAIL empty_pp: got lvl=%0d d=%h want lvl=1 d=77", o_level, o_tdata);
      end
      drive(0, '0, 1, 0, 1);
   endtask

   task automatic test_overrun_clr();
      for (int i = 0; i < DEPTH; i++) drive(1, 8'(i * 3), 0, 0, 1);
      drive(1, 8'hFF, 0, 0, 1);
      n_cmp++; if (o_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", o_overrun); end
      drive(1, 8'hEE, 0, 1, 1);
      n_cmp++; if (o_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set_wins: got %b want 1", o_overrun); end
      drive(0, '0, 0, 1, 1);
      n_cmp++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clr: got %b want 0", o_overrun); end
      drive(1, 8'hFF, 0, 0, 1);
   endtask

   task automatic test_midreset();
      drive(0, '0, 0, 0, 0);
      for (int i = 0; i < 5; i++) drive(1, 8'(8'h90 + i), 0, 0, 1);
      drive(0, '0, 0, 0, 0);
      n_cmp++; if (o_level !== 5'd0 || o_tvalid !== 1'b0 || o_overrun !== 1'b0) begin
         n_err++; $display("FAIL midreset: got lvl=%0d v=%b ovr=%b want 0/0/0", o_level, o_tvalid, o_overrun);
      end
      drive(1, 8'h3C, 0, 0, 1);
      n_cmp++; if (o_tdata !== 8'h3C || o_level !== 5'd1) begin
         n_err++; $display("FAIL post_reset_head: got d=%h lvl=%0d want d=3c lvl=1", o_tdata, o_level);
      end
   endtask

`ifdef UART_RX_FIFO_THRESH_EN
   task automatic test_thresh();
      drive(0, '0, 0, 0, 0);
      for (int i = 0; i < THRESH - 1; i++) drive(1, 8'(i), 0, 0, 1);
      n_cmp++; if (o_thresh !== 1'b0) begin n_err++; $display("FAIL thresh_below: got %b want 0", o_thresh); end
      drive(1, 8'hC0, 0, 0, 1);
      n_cmp++; if (o_thresh !== 1'b1 || o_level !== 5'(THRESH)) begin
         n_err++; $display("FAIL thresh_at: got t=%b lvl=%0d want t=1 lvl=%0d", o_thresh, o_level, THRESH);
      end
      drive(0, '0, 1, 0, 1);
      n_cmp++; if (o_thresh !== 1'b0) begin n_err++; $display("FAIL thresh_pop: got %b want 0", o_thresh); end
   endtask
`endif

   task automatic test_random();
      bit rv, tr, clr, rs;
      logic [DLEN-1:0] want_d;
      drive(0, '0, 0, 0, 0);
      for (int c = 0; c < 3000; c++) begin
         rv  = ($urandom % 2) == 0;
         tr  = ((c / 80) % 2 == 0) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
         clr = ($urandom % 16) == 0;
         rs  = ($urandom % 400) != 0;
         drive(rv, 8'($urandom), tr, clr, rs);
         want_d = (mq.size() > 0) ? mq[0] : '0;
         n_cmp++;
         if (o_level !== 5'(mq.size()) || o_tvalid !== (mq.size() > 0) || o_empty !== (mq.size() == 0) ||
             o_full !== (mq.size() == DEPTH) || o_overrun !== mov) begin
            n_err++;
            $display("FAIL rand_flags[%0d]: got lvl=%0d v=%b e=%b f=%b ovr=%b want lvl=%0d ovr=%b",
                     c, o_level, o_tvalid, o_empty, o_full, o_overrun, mq.size(), mov);
         end
         if (mq.size() > 0) begin
            n_cmp++;
            if (o_tdata !== want_d) begin n_err++; $display("FAIL rand_tdata[%0d]: got %h want %h", c, o_tdata, want_d); end
         end
`ifdef UART_RX_FIFO_THRESH_EN
         n_cmp++;
         if (o_thresh !== (mq.size() >= THRESH)) begin
            n_err++; $display("FAIL rand_thresh[%0d]: got %b want %b", c, o_thresh, mq.size() >= THRESH);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_overrun();
      test_full_pushpop();
      test_overrun_clr();
      test_midreset();
`ifdef UART_RX_FIFO_THRESH_EN
      test_thresh();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
